// File: rtl/button_event_ctrl.sv
// Push-button front end: sync, shared-tick debounce, press events, RR arbiter.
// Define AUTO_REPEAT_EN to build per-button auto-repeat on held buttons.
module button_event_ctrl #(
  parameter int N_BTN        = 5,
  parameter int TICK_DIV     = 1000000,
  parameter int STABLE_CNT   = 3,
  parameter int REPEAT_TICKS = 25
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_BTN-1:0]         btn_in,
  output logic [N_BTN-1:0]         btn_level,
  output logic                     evt_valid,
  output logic [$clog2(N_BTN)-1:0] evt_id,
  input  logic                     evt_ready,
  output logic                     evt_overrun
);

  localparam int IW = $clog2(N_BTN);
  localparam int CW = $clog2(TICK_DIV);

  logic [N_BTN-1:0]      sync1, sync2;
  logic [CW-1:0]         tick_cnt;
  logic                  tick;
  // older samples only; the newest sample is sync2 itself
  logic [STABLE_CNT-2:0] hist    [N_BTN];
  logic [STABLE_CNT-1:0] hist_nx [N_BTN];
  logic [N_BTN-1:0]      level_nx, press, set_vec;
  logic [N_BTN-1:0]      pending, clr_vec, rot;
  logic [IW-1:0]         last_grant, winner, off;
  logic [IW:0]           start, sum;
  logic                  found, load;

  assign tick = (tick_cnt == CW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1    <= '0;
      sync2    <= '0;
      tick_cnt <= '0;
    end else begin
      sync1    <= btn_in;
      sync2    <= sync1;
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < N_BTN; i++) begin
      hist_nx[i]  = {hist[i], sync2[i]};
      level_nx[i] = btn_level[i];
      if (tick) begin
        if (&hist_nx[i])
          level_nx[i] = 1'b1;
        else if (~|hist_nx[i])
          level_nx[i] = 1'b0;
      end
    end
  end

  assign press = level_nx & ~btn_level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_level <= '0;
      for (int i = 0; i < N_BTN; i++)
        hist[i] <= '0;
    end else if (tick) begin
      btn_level <= level_nx;
      for (int i = 0; i < N_BTN; i++)
        hist[i] <= hist_nx[i][STABLE_CNT-2:0];
    end
  end

`ifdef AUTO_REPEAT_EN
  localparam int RW = $clog2(REPEAT_TICKS + 1);

  logic [RW-1:0]    rpt_cnt [N_BTN];
  logic [N_BTN-1:0] rpt_set;

  always_comb begin
    for (int i = 0; i < N_BTN; i++)
      rpt_set[i] = tick && btn_level[i] && level_nx[i] &&
                   (rpt_cnt[i] == RW'(REPEAT_TICKS - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_BTN; i++)
        rpt_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        if (!level_nx[i] || press[i])
          rpt_cnt[i] <= '0;
        else if (tick && btn_level[i])
          rpt_cnt[i] <= rpt_set[i] ? '0 : rpt_cnt[i] + 1'b1;
      end
    end
  end

  assign set_vec = press | rpt_set;
`else
  assign set_vec = press;
`endif

  assign load = !evt_valid || evt_ready;

  // rotate so bit 0 is last_grant+1, pick lowest set bit, rotate back
  always_comb begin
    start = {1'b0, last_grant} + 1'b1;
    rot   = N_BTN'({pending, pending} >> start);
    off   = '0;
    for (int j = N_BTN - 1; j >= 0; j--)
      if (rot[j]) off = IW'(j);
    found = |rot;
    sum   = start + {1'b0, off};
    if (sum >= (IW+1)'(N_BTN))
      sum = sum - (IW+1)'(N_BTN);
    winner  = sum[IW-1:0];
    clr_vec = (load && found) ? (N_BTN'(1) << winner) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending     <= '0;
      evt_valid   <= 1'b0;
      evt_id      <= '0;
      evt_overrun <= 1'b0;
      last_grant  <= IW'(N_BTN - 1);
    end else begin
      pending     <= (pending & ~clr_vec) | set_vec;
      evt_overrun <= |(set_vec & pending & ~clr_vec);
      if (load) begin
        evt_valid <= found;
        if (found) begin
          evt_id     <= winner;
          last_grant <= winner;
        end
      end
    end
  end

endmodule
